// File: rtl/cpu_pkg.sv
// Shared core definitions: exception codes, the NOP encoding and the
// pipeline-stage occupancy state encoding.
package cpu_pkg;

  localparam int CPU_EXC_W = 5;

  localparam logic [CPU_EXC_W-1:0] EXC_INT  = 5'd0;
  localparam logic [CPU_EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [CPU_EXC_W-1:0] EXC_RI   = 5'd10;
  localparam logic [CPU_EXC_W-1:0] EXC_OV   = 5'd12;

  // sll $0,$0,0 -- the canonical MIPS bubble.
  localparam logic [31:0] CPU_NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One payload register of a pipeline stage: loads on demand, clears to a
// fixed bubble value on reset or clear.
module pipe_slot #(
  parameter int            W       = 70,
  parameter logic [W-1:0]  CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: the payload itself is reset, not only a valid bit, because an empty
  // slot must always present a NOP bubble downstream.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values.
      q <= CLR_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register for instr/PC/ExcCode/delay-slot payload,
// with an optional 2-entry skid buffer that keeps in_ready off the comb path.
module pipe_stage_skid
  import cpu_pkg::*;
#(
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_W      = 32,
  parameter int                 EXC_W     = CPU_EXC_W,
  parameter bit                 SKID      = 1'b1,
  parameter logic [INSTR_W-1:0] NOP_INSTR = CPU_NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [EXC_W-1:0]   in_exc,
  input  logic               in_bd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [EXC_W-1:0]   out_exc,
  output logic               out_bd,
  output logic [1:0]         occupancy
);

  localparam int             PAY_W   = INSTR_W + PC_W + EXC_W + 1;
  localparam logic [PAY_W-1:0] PAY_NOP = {NOP_INSTR, {(PC_W + EXC_W + 1){1'b0}}};

  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] head_q;

  assign in_pay = {in_instr, in_pc, in_exc, in_bd};
  assign {out_instr, out_pc, out_exc, out_bd} = head_q;

  if (SKID) begin : g_skid
    skid_state_e      state_q, state_d;
    logic             in_ready_q;
    logic             push, pop;
    logic             head_load, head_clear, head_from_skid;
    logic             skid_load, skid_clear;
    logic [PAY_W-1:0] skid_q;
    logic [PAY_W-1:0] head_d;

    assign push      = in_valid & in_ready_q;
    assign pop       = (state_q != ST_EMPTY) & out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign occupancy = state_q;
    assign head_d    = head_from_skid ? skid_q : in_pay;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
      state_d        = state_q;
      head_load      = 1'b0;
      head_clear     = 1'b0;
      head_from_skid = 1'b0;
      skid_load      = 1'b0;
      skid_clear     = 1'b0;
      if (flush) begin
        state_d    = ST_EMPTY;
        head_clear = 1'b1;
        skid_clear = 1'b1;
      end else begin
        unique case (state_q)
          ST_EMPTY: begin
            if (push) begin
              state_d   = ST_ONE;
              head_load = 1'b1;
            end
          end
          ST_ONE: begin
            if (push && !pop) begin
              state_d   = ST_FULL;
              skid_load = 1'b1;
            end else if (push && pop) begin
              head_load = 1'b1;
            end else if (pop) begin
              state_d    = ST_EMPTY;
              head_clear = 1'b1;
            end
          end
          ST_FULL: begin
            // in_ready is low here, so only a pop can happen.
            if (pop) begin
              state_d        = ST_ONE;
              head_load      = 1'b1;
              head_from_skid = 1'b1;
              skid_clear     = 1'b1;
            end
          end
          default: begin
            state_d    = ST_EMPTY;
            head_clear = 1'b1;
            skid_clear = 1'b1;
          end
        endcase
      end
    end

    // in_ready is computed from the next state so it is already low in the
    // first FULL cycle and no push can ever be lost.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q    <= ST_EMPTY;
        in_ready_q <= 1'b1;
      end else begin
        state_q    <= state_d;
        in_ready_q <= (state_d != ST_FULL);
      end
    end

    pipe_slot #(.W(PAY_W), .CLR_VAL(PAY_NOP)) u_head (
      .clk   (clk),
      .reset (reset),
      .clear (head_clear),
      .load  (head_load),
      .d     (head_d),
      .q     (head_q)
    );

    pipe_slot #(.W(PAY_W), .CLR_VAL(PAY_NOP)) u_skid (
      .clk   (clk),
      .reset (reset),
      .clear (skid_clear),
      .load  (skid_load),
      .d     (in_pay),
      .q     (skid_q)
    );
  end else begin : g_pass
    logic valid_q;
    logic push, pop;

    assign in_ready  = ~valid_q | out_ready;
    assign push      = in_valid & in_ready;
    assign pop       = valid_q & out_ready;
    assign out_valid = valid_q;
    assign occupancy = {1'b0, valid_q};

    always_ff @(posedge clk) begin
      if (reset || flush) begin
        valid_q <= 1'b0;
      end else if (push) begin
        valid_q <= 1'b1;
      end else if (pop) begin
        valid_q <= 1'b0;
      end
    end

    pipe_slot #(.W(PAY_W), .CLR_VAL(PAY_NOP)) u_head (
      .clk   (clk),
      .reset (reset),
      .clear (flush | (pop & ~push)),
      .load  (push),
      .d     (in_pay),
      .q     (head_q)
    );
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a SKID=1 and a SKID=0 instance, each checked by a
// queue-based reference model, plus directed scenarios for the corner cases.
module tb_pipe_stage_skid;
  import cpu_pkg::*;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  exc;
    logic        bd;
  } pkt_t;

  logic clk = 1'b0;
  logic reset;

  // SKID=1 instance signals
  logic        flush, in_valid, in_ready, in_bd, out_valid, out_ready, out_bd;
  logic [31:0] in_instr, in_pc, out_instr, out_pc;
  logic [4:0]  in_exc, out_exc;
  logic [1:0]  occupancy;

  // SKID=0 instance signals
  logic        z_flush, z_in_valid, z_in_ready, z_in_bd, z_out_valid, z_out_ready, z_out_bd;
  logic [31:0] z_in_instr, z_in_pc, z_out_instr, z_out_pc;
  logic [4:0]  z_in_exc, z_out_exc;
  logic [1:0]  z_occupancy;

  int checks = 0;
  int errors = 0;

  pkt_t q1[$];
  pkt_t q0[$];
  pkt_t exp1, exp0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.SKID(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_exc(in_exc), .in_bd(in_bd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_exc(out_exc), .out_bd(out_bd),
    .occupancy(occupancy)
  );

  pipe_stage_skid #(.SKID(1'b0)) dut0 (
    .clk(clk), .reset(reset), .flush(z_flush),
    .in_valid(z_in_valid), .in_ready(z_in_ready),
    .in_instr(z_in_instr), .in_pc(z_in_pc), .in_exc(z_in_exc), .in_bd(z_in_bd),
    .out_valid(z_out_valid), .out_ready(z_out_ready),
    .out_instr(z_out_instr), .out_pc(z_out_pc), .out_exc(z_out_exc), .out_bd(z_out_bd),
    .occupancy(z_occupancy)
  );

  task automatic check(input string name, input logic [69:0] actual, input logic [69:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                        input logic [4:0] exc, input logic bd);
    in_valid = v; in_instr = instr; in_pc = pc; in_exc = exc; in_bd = bd;
  endtask

  task automatic set_z(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [4:0] exc, input logic bd);
    z_in_valid = v; z_in_instr = instr; z_in_pc = pc; z_in_exc = exc; z_in_bd = bd;
  endtask

  // Monitor: at the negedge the inputs for the coming edge are stable, so the
  // model first checks what the DUT presents, then applies this cycle's handshakes.
  always @(negedge clk) begin
    if (reset) begin
      q1.delete();
      q0.delete();
    end else begin
      exp1 = (q1.size() != 0) ? q1[0] : '0;
      check("s1_valid", out_valid, q1.size() != 0);
      check("s1_occupancy", occupancy, q1.size());
      check("s1_in_ready", in_ready, q1.size() < 2);
      check("s1_head", {out_instr, out_pc, out_exc, out_bd}, exp1);
      if (flush) begin
        q1.delete();
      end else begin
        automatic bit can_push = (q1.size() < 2);
        if (q1.size() != 0 && out_ready) q1.delete(0);
        if (in_valid && can_push) q1.push_back(pkt_t'({in_instr, in_pc, in_exc, in_bd}));
      end

      exp0 = (q0.size() != 0) ? q0[0] : '0;
      check("s0_valid", z_out_valid, q0.size() != 0);
      check("s0_occupancy", z_occupancy, q0.size());
      check("s0_in_ready", z_in_ready, (q0.size() == 0) || z_out_ready);
      check("s0_head", {z_out_instr, z_out_pc, z_out_exc, z_out_bd}, exp0);
      if (z_flush) begin
        q0.delete();
      end else begin
        automatic bit can_push0 = (q0.size() == 0) || z_out_ready;
        if (q0.size() != 0 && z_out_ready) q0.delete(0);
        if (z_in_valid && can_push0) q0.push_back(pkt_t'({z_in_instr, z_in_pc, z_in_exc, z_in_bd}));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    set_in(1'b1, 32'h2401_00ff, 32'h0000_2000, EXC_RI, 1'b1);
    z_flush = 1'b0; z_out_ready = 1'b0;
    set_z(1'b0, '0, '0, '0, 1'b0);

    // Reset held two cycles with in_valid high.
    tick(); tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_instr", out_instr, CPU_NOP_INSTR);
    check("rst_occupancy", occupancy, 2'd0);
    check("rst_in_ready", in_ready, 1'b1);
    reset = 1'b0;
    set_in(1'b0, '0, '0, '0, 1'b0);
    tick();

    // Back-to-back streaming with out_ready high.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 32'h2401_0001 + i, 32'h3000 + 4 * i, EXC_INT, 1'b0);
      tick();
      check("stream_instr", out_instr, 32'h2401_0001 + i);
      check("stream_pc", out_pc, 32'h3000 + 4 * i);
      check("stream_in_ready", in_ready, 1'b1);
      check("stream_occupancy", occupancy, 2'd1);
    end
    set_in(1'b0, '0, '0, '0, 1'b0);
    tick();
    check("stream_drained", occupancy, 2'd0);

    // Stall: two entries fill head and skid, then drain in order.
    out_ready = 1'b0;
    set_in(1'b1, 32'h8c01_0000, 32'h3000, EXC_INT, 1'b0); tick();
    set_in(1'b1, 32'h8c02_0004, 32'h3004, EXC_INT, 1'b0); tick();
    set_in(1'b0, '0, '0, '0, 1'b0);
    check("stall_occupancy", occupancy, 2'd2);
    check("stall_in_ready", in_ready, 1'b0);
    check("stall_pc", out_pc, 32'h3000);
    tick();
    check("stall_pc_held", out_pc, 32'h3000);
    out_ready = 1'b1;
    tick();
    check("release_pc_b", out_pc, 32'h3004);
    check("release_occupancy", occupancy, 2'd1);
    check("release_in_ready", in_ready, 1'b1);
    tick();
    check("release_empty", out_valid, 1'b0);

    // Flush while FULL with another entry offered.
    out_ready = 1'b0;
    set_in(1'b1, 32'h8c01_0000, 32'h3000, EXC_INT, 1'b0); tick();
    set_in(1'b1, 32'h8c02_0004, 32'h3004, EXC_INT, 1'b0); tick();
    flush = 1'b1;
    set_in(1'b1, 32'h8c03_0008, 32'h3008, EXC_INT, 1'b0);
    tick();
    flush = 1'b0;
    set_in(1'b0, '0, '0, '0, 1'b0);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_out_instr", out_instr, CPU_NOP_INSTR);
    check("flush_occupancy", occupancy, 2'd0);
    check("flush_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    tick(); tick();
    check("flush_no_leak", out_valid, 1'b0);

    // Exception payload passes through untouched.
    out_ready = 1'b0;
    set_in(1'b1, 32'h0085_1020, 32'h4180, EXC_OV, 1'b1);
    tick();
    set_in(1'b0, '0, '0, '0, 1'b0);
    check("exc_code", out_exc, EXC_OV);
    check("exc_bd", out_bd, 1'b1);
    check("exc_pc", out_pc, 32'h4180);
    out_ready = 1'b1;
    tick();
    check("exc_cleared", out_exc, EXC_INT);
    check("exc_bd_cleared", out_bd, 1'b0);

    // Random traffic on both instances, judged by the monitor.
    for (int i = 0; i < 500; i++) begin
      flush     = ($urandom_range(0, 31) == 0);
      out_ready = flush ? 1'b0 : ($urandom_range(0, 2) != 0);
      set_in($urandom_range(0, 3) != 0, $urandom, $urandom, 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)));
      z_flush     = ($urandom_range(0, 31) == 0);
      z_out_ready = z_flush ? 1'b0 : ($urandom_range(0, 2) != 0);
      set_z($urandom_range(0, 3) != 0, $urandom, $urandom, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)));
      tick();
    end
    flush = 1'b0; out_ready = 1'b1; set_in(1'b0, '0, '0, '0, 1'b0);
    z_flush = 1'b0; z_out_ready = 1'b1; set_z(1'b0, '0, '0, '0, 1'b0);
    repeat (4) tick();
    check("drain_s1", occupancy, 2'd0);
    check("drain_s0", z_occupancy, 2'd0);

    // SKID=0: combinational in_ready and head replacement.
    z_out_ready = 1'b0;
    set_z(1'b1, 32'h2402_0005, 32'h5000, EXC_INT, 1'b0);
    #1 check("s0_empty_ready", z_in_ready, 1'b1);
    tick();
    set_z(1'b0, '0, '0, '0, 1'b0);
    check("s0_loaded_pc", z_out_pc, 32'h5000);
    check("s0_loaded_occ", z_occupancy, 2'd1);
    #1 check("s0_stall_ready", z_in_ready, 1'b0);
    set_z(1'b1, 32'h2403_0006, 32'h5004, EXC_ADEL, 1'b1);
    tick();
    check("s0_held_pc", z_out_pc, 32'h5000);
    z_out_ready = 1'b1;
    #1 check("s0_pass_ready", z_in_ready, 1'b1);
    tick();
    check("s0_replaced_pc", z_out_pc, 32'h5004);
    check("s0_replaced_exc", z_out_exc, EXC_ADEL);
    check("s0_replaced_occ", z_occupancy, 2'd1);
    set_z(1'b0, '0, '0, '0, 1'b0);
    tick();
    check("s0_pop_valid", z_out_valid, 1'b0);
    check("s0_pop_pc", z_out_pc, 32'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
